// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared MIPS definitions for the write-back stage
package regfile_wb_pkg;

    localparam int ADDR_SIZE_DEF = 5;
    localparam int WORD_SIZE_DEF = 32;
    localparam int REG_ZERO      = 0;

endpackage

// File: rtl/regfile_wb_fifo.sv
// wb_fifo: small power-of-two FIFO buffering load results awaiting a write port
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full_o  = count == (PW+1)'(DEPTH);
    assign empty_o = count == '0;
    assign head_o  = mem[rd_ptr];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    // storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: register-file write-back arbiter (ALU first, buffered loads) with load scoreboard
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int MEM_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alu_valid_i,
    input  logic [ADDR_SIZE-1:0] alu_rd_i,
    input  logic [WORD_SIZE-1:0] alu_data_i,
    input  logic                 mem_valid_i,
    output logic                 mem_ready_o,
    input  logic [ADDR_SIZE-1:0] mem_rd_i,
    input  logic [WORD_SIZE-1:0] mem_data_i,
    input  logic                 iss_en_i,
    input  logic [ADDR_SIZE-1:0] iss_rd_i,
    input  logic [ADDR_SIZE-1:0] rs_i,
    input  logic [ADDR_SIZE-1:0] rt_i,
    output logic                 rs_busy_o,
    output logic                 rt_busy_o,
    output logic                 rd_en_o,
    output logic [ADDR_SIZE-1:0] rd_o,
    output logic [WORD_SIZE-1:0] rd_data_o
);

    localparam int NREG = 2 ** ADDR_SIZE;
    localparam int EW   = ADDR_SIZE + WORD_SIZE;
    localparam logic [ADDR_SIZE-1:0] RZ = ADDR_SIZE'(REG_ZERO);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [EW-1:0]        fifo_head;
    logic                 alu_wr;
    logic                 mem_push;
    logic                 bypass;
    logic                 ld_take;
    logic                 ld_wr;
    logic [ADDR_SIZE-1:0] ld_rd;
    logic [WORD_SIZE-1:0] ld_data;
    logic [NREG-1:0]      pending;
    logic [NREG-1:0]      set_mask;
    logic [NREG-1:0]      clr_mask;

    assign alu_wr      = alu_valid_i && alu_rd_i != RZ;
    assign mem_ready_o = !fifo_full;
    assign mem_push    = mem_valid_i && mem_ready_o;
    // an empty FIFO with a free write port lets the offered load go straight out
    assign bypass      = fifo_empty && mem_push && !alu_wr;
    assign ld_take     = !alu_wr && (!fifo_empty || mem_push);
    assign ld_rd       = fifo_empty ? mem_rd_i : fifo_head[EW-1:WORD_SIZE];
    assign ld_data     = fifo_empty ? mem_data_i : fifo_head[WORD_SIZE-1:0];
    assign ld_wr       = ld_take && ld_rd != RZ;
    assign set_mask    = (iss_en_i && iss_rd_i != RZ) ? NREG'(1) << iss_rd_i : '0;
    assign clr_mask    = ld_wr ? NREG'(1) << ld_rd : '0;
    assign rs_busy_o   = pending[rs_i];
    assign rt_busy_o   = pending[rt_i];

    wb_fifo #(
        .DEPTH(MEM_DEPTH),
        .W    (EW)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (mem_push && !bypass),
        .pop_i  (ld_take && !fifo_empty),
        .data_i ({mem_rd_i, mem_data_i}),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .head_o (fifo_head)
    );

    // write port: ALU wins, else a load; address/data hold when nothing is written
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_en_o   <= 1'b0;
            rd_o      <= '0;
            rd_data_o <= '0;
        end else begin
            rd_en_o <= alu_wr || ld_wr;
            if (alu_wr) begin
                rd_o      <= alu_rd_i;
                rd_data_o <= alu_data_i;
            end else if (ld_wr) begin
                rd_o      <= ld_rd;
                rd_data_o <= ld_data;
            end
        end
    end

    // pending-load mask: a new issue outranks a same-cycle commit to the same register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pending <= '0;
        else pending <= (pending & ~clr_mask) | set_mask;
    end

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed self-checking bench for regfile_wb
module tb_regfile_wb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [4:0]  mem_rd_i;
    logic [31:0] mem_data_i;
    logic        iss_en_i;
    logic [4:0]  iss_rd_i;
    logic [4:0]  rs_i;
    logic [4:0]  rt_i;
    logic        rs_busy_o;
    logic        rt_busy_o;
    logic        rd_en_o;
    logic [4:0]  rd_o;
    logic [31:0] rd_data_o;

    int total = 0;
    int bad   = 0;

    regfile_wb dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .alu_valid_i(alu_valid_i),
        .alu_rd_i   (alu_rd_i),
        .alu_data_i (alu_data_i),
        .mem_valid_i(mem_valid_i),
        .mem_ready_o(mem_ready_o),
        .mem_rd_i   (mem_rd_i),
        .mem_data_i (mem_data_i),
        .iss_en_i   (iss_en_i),
        .iss_rd_i   (iss_rd_i),
        .rs_i       (rs_i),
        .rt_i       (rt_i),
        .rs_busy_o  (rs_busy_o),
        .rt_busy_o  (rt_busy_o),
        .rd_en_o    (rd_en_o),
        .rd_o       (rd_o),
        .rd_data_o  (rd_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_en"}, 32'(rd_en_o), 32'(en));
        chk({tag, "_rd"}, 32'(rd_o), 32'(rd));
        chk({tag, "_data"}, rd_data_o, d);
    endtask

    initial begin
        rst_i = 1'b1;
        alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
        mem_valid_i = 0; mem_rd_i = 0; mem_data_i = 0;
        iss_en_i = 0; iss_rd_i = 0; rs_i = 0; rt_i = 0;
        #3;
        wr("rst", 0, 0, 0);
        chk("rst_ready", 32'(mem_ready_o), 1);
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        wr("idle", 0, 0, 0);

        // single ALU write, then hold
        alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'hDEADBEEF;
        tick();
        wr("alu", 1, 5, 32'hDEADBEEF);
        alu_valid_i = 0;
        tick();
        wr("hold", 0, 5, 32'hDEADBEEF);

        // scoreboard on r7
        iss_en_i = 1; iss_rd_i = 7; rs_i = 7; rt_i = 4;
        chk("sb_pre", 32'(rs_busy_o), 0);
        tick();
        iss_en_i = 0;
        chk("sb_set", 32'(rs_busy_o), 1);
        chk("sb_rt", 32'(rt_busy_o), 0);
        tick();
        chk("sb_keep", 32'(rs_busy_o), 1);
        mem_valid_i = 1; mem_rd_i = 7; mem_data_i = 32'h77;
        iss_en_i = 1; iss_rd_i = 7;
        tick();
        wr("sb_ld1", 1, 7, 32'h77);
        chk("sb_reissue", 32'(rs_busy_o), 1);
        mem_valid_i = 0; iss_en_i = 0;
        tick();
        chk("sb_still", 32'(rs_busy_o), 1);
        mem_valid_i = 1; mem_data_i = 32'h78;
        tick();
        mem_valid_i = 0;
        wr("sb_ld2", 1, 7, 32'h78);
        chk("sb_clr", 32'(rs_busy_o), 0);

        // ALU/load collision
        iss_en_i = 1; iss_rd_i = 4;
        tick();
        iss_en_i = 0;
        chk("col_busy", 32'(rt_busy_o), 1);
        alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'h11;
        mem_valid_i = 1; mem_rd_i = 4; mem_data_i = 32'h22;
        chk("col_ready", 32'(mem_ready_o), 1);
        tick();
        alu_valid_i = 0; mem_valid_i = 0;
        wr("col_c1", 1, 3, 32'h11);
        chk("col_busy1", 32'(rt_busy_o), 1);
        tick();
        wr("col_c2", 1, 4, 32'h22);
        chk("col_busy2", 32'(rt_busy_o), 0);

        // backpressure while ALU owns the port
        alu_valid_i = 1; alu_rd_i = 1; alu_data_i = 32'hA0;
        mem_valid_i = 1; mem_rd_i = 8; mem_data_i = 32'hA1;
        chk("bp_rdy0", 32'(mem_ready_o), 1);
        tick();
        wr("bp_alu0", 1, 1, 32'hA0);
        alu_data_i = 32'hB0; mem_rd_i = 9; mem_data_i = 32'hB2;
        chk("bp_rdy1", 32'(mem_ready_o), 1);
        tick();
        wr("bp_alu1", 1, 1, 32'hB0);
        alu_data_i = 32'hC0; mem_rd_i = 10; mem_data_i = 32'hC3;
        chk("bp_full", 32'(mem_ready_o), 0);
        tick();
        wr("bp_alu2", 1, 1, 32'hC0);
        chk("bp_full2", 32'(mem_ready_o), 0);
        alu_valid_i = 0; mem_valid_i = 0;
        tick();
        wr("bp_d1", 1, 8, 32'hA1);
        chk("bp_rdy2", 32'(mem_ready_o), 1);
        tick();
        wr("bp_d2", 1, 9, 32'hB2);
        tick();
        wr("bp_idle", 0, 9, 32'hB2);

        // register zero is never written or marked busy
        alu_valid_i = 1; alu_rd_i = 0; alu_data_i = 32'h55;
        mem_valid_i = 1; mem_rd_i = 0; mem_data_i = 32'h66;
        iss_en_i = 1; iss_rd_i = 0; rs_i = 0; rt_i = 0;
        tick();
        alu_valid_i = 0; mem_valid_i = 0; iss_en_i = 0;
        wr("r0", 0, 9, 32'hB2);
        chk("r0_rs", 32'(rs_busy_o), 0);
        chk("r0_rt", 32'(rt_busy_o), 0);
        tick();
        wr("r0_after", 0, 9, 32'hB2);
        chk("r0_ready", 32'(mem_ready_o), 1);

        // bypass: load alone commits after one cycle
        mem_valid_i = 1; mem_rd_i = 12; mem_data_i = 32'hC3;
        tick();
        mem_valid_i = 0;
        wr("byp", 1, 12, 32'hC3);

        // async reset with two buffered loads
        alu_valid_i = 1; alu_rd_i = 2; alu_data_i = 32'h20;
        mem_valid_i = 1; mem_rd_i = 13; mem_data_i = 32'hD1;
        iss_en_i = 1; iss_rd_i = 13; rs_i = 13;
        tick();
        iss_en_i = 0; mem_rd_i = 14; mem_data_i = 32'hD2;
        tick();
        mem_valid_i = 0;
        chk("ar_full", 32'(mem_ready_o), 0);
        chk("ar_busy", 32'(rs_busy_o), 1);
        wr("ar_pre", 1, 2, 32'h20);
        alu_valid_i = 0;
        #2;
        rst_i = 1'b1;
        #1;
        wr("ar_rst", 0, 0, 0);
        chk("ar_ready", 32'(mem_ready_o), 1);
        chk("ar_rs", 32'(rs_busy_o), 0);
        tick();
        rst_i = 1'b0;
        tick();
        wr("ar_post1", 0, 0, 0);
        tick();
        wr("ar_post2", 0, 0, 0);
        chk("ar_ready2", 32'(mem_ready_o), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
